uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk_i cycles per serial bit; SHALL be >= 4. Elaboration SHALL fail otherwise.
REQ-002 Port clk_i  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 Port rx_i  input  1  asynchronous serial line; idle high.
REQ-005 Port data_o  output  8  last received byte; valid while valid_o=1.
REQ-006 Port valid_o  output  1  byte available; held until accepted.
REQ-007 Port ready_i  input  1  consumer accepts data_o when valid_o=1 and ready_i=1 in the same cycle.
REQ-008 Port frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-009 Port overrun_o  output  1  one-cycle pulse when a good byte is lost.
REQ-010 Port busy_o  output  1  high in every state except IDLE.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, matching the team's UART transmitter.
REQ-012 rx_i SHALL pass through a 2-flop synchronizer; all logic below SHALL use only the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on a falling edge of rx_s (previous value 1, current value 0); the bit counter SHALL be cleared on entry to START.
REQ-015 START: sample rx_s when the counter reaches CLKS_PER_BIT/2-1 (integer division); if 0, go to DATA with the counter cleared; if 1, it is a false start and the FSM SHALL return to IDLE with no output pulse.
REQ-016 DATA: sample once every CLKS_PER_BIT cycles (mid-bit); shift the sample into the MSB of the shift register, shifting right; after 8 samples, go to STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; then return to IDLE in the next cycle.
REQ-018 STOP sample = 1: data_o SHALL load the shift register and valid_o SHALL assert in the next cycle (latency 1 clk from the stop sample).
REQ-019 STOP sample = 0: frame_err_o SHALL pulse for one cycle; data_o and valid_o SHALL be unchanged.
REQ-020 valid_o SHALL clear on the cycle after a handshake (valid_o=1 and ready_i=1), unless a new byte loads in that same cycle, in which case valid_o SHALL stay 1 with the new data.
REQ-021 A good byte completing while valid_o=1 and ready_i=0: overrun_o SHALL pulse one cycle, the new byte SHALL be discarded, and data_o SHALL keep the old byte.
REQ-022 Counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL wrap to 0 at each sample point, never at 2**width.
REQ-023 A low level held in IDLE (line break) SHALL NOT re-trigger reception; a falling edge is required.

Reset
REQ-024 While rst_i is high: FSM SHALL be in IDLE; data_o, valid_o, frame_err_o, overrun_o and busy_o SHALL be 0; synchronizer flops and the previous-value flop SHALL be 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulses; the next valid frame SHALL be received correctly.

Structure
REQ-026 Package uart_pkg SHALL hold the rx state enum typedef and the constant DATA_BITS=8; uart_rx SHALL import it.
REQ-027 The synchronizer SHALL be a separate sub-module, uart_sync: 2 flops, parameterized reset value, default 1.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0xA5, ready_i=1 -> data_o=0xA5 with valid_o high for exactly 1 cycle; frame_err_o=0; overrun_o=0.
REQ-029 rx_i low for 3 cycles, then high -> no valid_o and no frame_err_o; busy_o returns to 0 within 8 cycles.
REQ-030 Frame 0x5A with stop bit 0 -> frame_err_o pulses once; valid_o stays 0.
REQ-031 Frames 0x3C then 0xC3 back-to-back, ready_i=0 -> overrun_o pulses once; data_o=0x3C; valid_o stays 1.
REQ-032 rst_i pulsed during data bit 4, then frame 0x81 -> all outputs 0 during reset; afterwards data_o=0x81 with valid_o pulse.
REQ-033 Loopback from the team's UART transmitter, bytes 0x00, 0xFF, 0x55 -> received in order with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame width and receiver state encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; reset value is configurable.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-entry output register with valid/ready handshake,
// frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_param_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    logic                 rx_s;
    logic                 prev_q;
    rx_state_e            state_q,     state_d;
    logic [CW-1:0]        cnt_q,       cnt_d;
    logic [2:0]           bit_q,       bit_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 busy_q,      busy_d;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~ready_i;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Only a 1->0 transition starts a frame; a held-low line stays idle.
                if (prev_q && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else if (valid_q && !ready_i) begin
                        // Unconsumed byte still held: keep it and drop the new one.
                        overrun_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            prev_q      <= rx_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a serial-frame task stands in for the transmitter.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    // Event counters and received-byte log, only ever written by the monitor.
    int         valid_cycles = 0;
    int         valid_rises  = 0;
    int         err_pulses   = 0;
    int         ovr_pulses   = 0;
    int         busy_cycles  = 0;
    logic       valid_prev   = 1'b0;
    logic [7:0] got_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (valid_o) valid_cycles++;
        if (valid_o && !valid_prev) valid_rises++;
        if (frame_err_o) err_pulses++;
        if (overrun_o) ovr_pulses++;
        if (busy_o) busy_cycles++;
        if (valid_o && ready_i) got_q.push_back(data_o);
        valid_prev = valid_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = stop_bit;
        tick(CPB);
        rx_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        tick(3);
        @(negedge clk_i);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if ({frame_err_o, overrun_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_err_o, overrun_o}); end
        tick(1);
        rst_i = 1'b0;
        tick(10);
    endtask

    task automatic test_good_byte;
        int v0 = valid_cycles, e0 = err_pulses, o0 = ovr_pulses, q0 = got_q.size();
        send_frame(8'hA5, 1'b1);
        tick(20);
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL good_valid_cycles: got %0d expected 1", valid_cycles - v0); end
        checks++;
        if (got_q.size() != q0 + 1) begin errors++; $display("FAIL good_count: got %0d expected 1", got_q.size() - q0); end
        else if (got_q[q0] !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected a5", got_q[q0]); end
        checks++; if (err_pulses - e0 != 0) begin errors++; $display("FAIL good_frame_err: got %0d expected 0", err_pulses - e0); end
        checks++; if (ovr_pulses - o0 != 0) begin errors++; $display("FAIL good_overrun: got %0d expected 0", ovr_pulses - o0); end
    endtask

    task automatic test_false_start;
        int v0 = valid_cycles, e0 = err_pulses, b0 = busy_cycles;
        int n = 0;
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        while (busy_o && n < 8) begin
            tick(1);
            n++;
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL false_busy_clear: got %b expected 0 within 8 cycles", busy_o); end
        checks++; if (busy_cycles == b0) begin errors++; $display("FAIL false_busy_seen: got 0 busy cycles expected >0"); end
        tick(10);
        checks++; if (valid_cycles - v0 != 0) begin errors++; $display("FAIL false_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if (err_pulses - e0 != 0) begin errors++; $display("FAIL false_frame_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_frame_error;
        int v0 = valid_cycles, e0 = err_pulses;
        send_frame(8'h5A, 1'b0);
        tick(20);
        checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", err_pulses - e0); end
        checks++; if (valid_cycles - v0 != 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h expected a5", data_o); end
    endtask

    task automatic test_back_to_back;
        int r0 = valid_rises, o0 = ovr_pulses, e0 = err_pulses;
        ready_i = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(20);
        checks++; if (ovr_pulses - o0 != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_pulses - o0); end
        checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL ovr_data: got %h expected 3c", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", valid_o); end
        checks++; if (valid_rises - r0 != 1) begin errors++; $display("FAIL ovr_valid_rises: got %0d expected 1", valid_rises - r0); end
        checks++; if (err_pulses - e0 != 0) begin errors++; $display("FAIL ovr_frame_err: got %0d expected 0", err_pulses - e0); end
        ready_i = 1'b1;
        tick(1);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_valid_release: got %b expected 0", valid_o); end
        tick(5);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b = 8'h81;
        int e0 = err_pulses, o0 = ovr_pulses, v0, q0;
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = b[4];
        tick(8);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b expected 1", busy_o); end
        rst_i = 1'b1;
        rx_i  = 1'b1;
        @(negedge clk_i);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", data_o); end
        checks++; if ({valid_o, frame_err_o, overrun_o, busy_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {valid_o, frame_err_o, overrun_o, busy_o}); end
        tick(3);
        rst_i = 1'b0;
        tick(40);
        v0 = valid_cycles;
        q0 = got_q.size();
        send_frame(8'h81, 1'b1);
        tick(20);
        checks++;
        if (got_q.size() != q0 + 1) begin errors++; $display("FAIL rst_after_count: got %0d expected 1", got_q.size() - q0); end
        else if (got_q[q0] !== 8'h81) begin errors++; $display("FAIL rst_after_data: got %h expected 81", got_q[q0]); end
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL rst_after_valid: got %0d expected 1", valid_cycles - v0); end
        checks++; if ((err_pulses - e0) + (ovr_pulses - o0) != 0) begin errors++; $display("FAIL rst_pulses: got %0d expected 0", (err_pulses - e0) + (ovr_pulses - o0)); end
    endtask

    task automatic test_loopback;
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h55};
        int e0 = err_pulses, o0 = ovr_pulses, q0 = got_q.size();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
        tick(20);
        checks++; if (got_q.size() - q0 != 3) begin errors++; $display("FAIL loop_count: got %0d expected 3", got_q.size() - q0); end
        for (int i = 0; i < 3; i++) begin
            if (q0 + i < got_q.size()) begin
                checks++;
                if (got_q[q0 + i] !== bytes[i]) begin errors++; $display("FAIL loop_byte%0d: got %h expected %h", i, got_q[q0 + i], bytes[i]); end
            end
        end
        checks++; if ((err_pulses - e0) + (ovr_pulses - o0) != 0) begin errors++; $display("FAIL loop_pulses: got %0d expected 0", (err_pulses - e0) + (ovr_pulses - o0)); end
    endtask

    initial begin
        test_reset();
        test_good_byte();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete within 400000 ns");
        $fatal(1, "timeout");
    end

endmodule
